ps2_host_tx: RTL and testbench
==============================

// Module: ps2_host_tx
// PURPOSE
//  Host-to-device PS/2 transmitter; the send side of our PS/2 keyboard receive path.
//  Sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) to the keyboard over open-drain CLK/DAT.
//  Frame on the wire: start, 8 data bits LSB-first, odd parity, stop, then device ACK.
//  Sits beside the receive controlpath/datapath. The top level ties the *_oe outputs to tri-state PS2_CLK/PS2_DAT.
// PARAMETERS
//  INHIBIT_CYCLES  5000    CLOCK_50 cycles the host holds CLK low before the request (100 us @ 50 MHz)
//  TIMEOUT_CYCLES  750000  max CLOCK_50 cycles between device falling edges before abort (15 ms)
//  CNT_W           20      width of the shared cycle counter; must hold max(INHIBIT_CYCLES, TIMEOUT_CYCLES)
// PORTS
//  CLOCK_50     in   1  system clock
//  resetn       in   1  asynchronous, active-low reset
//  ps2_clk_in   in   1  PS2_CLK pin level (asynchronous)
//  ps2_dat_in   in   1  PS2_DAT pin level (asynchronous)
//  ps2_clk_oe   out  1  1 = drive PS2_CLK low, 0 = release (high-Z)
//  ps2_dat_oe   out  1  1 = drive PS2_DAT low, 0 = release (high-Z)
//  tx_data      in   8  command byte
//  tx_valid     in   1  send request; accepted only while tx_ready=1
//  tx_ready     out  1  1 only in IDLE
//  busy         out  1  1 in every state except IDLE
//  done         out  1  1-cycle pulse: transfer finished (with or without ACK)
//  ack_err      out  1  1-cycle pulse with done: device did not pull DAT low at ACK
//  timeout_err  out  1  1-cycle pulse: transfer aborted by timeout (done stays 0)
// BEHAVIOUR
//  - Reset (async): state=IDLE; ps2_clk_oe=0, ps2_dat_oe=0, tx_ready=1; busy=done=ack_err=timeout_err=0.
//    Reset mid-transfer releases both lines immediately. No partial frame resumes.
//  - ps2_clk_in and ps2_dat_in each pass through 2-FF synchronisers.
//  - fall = synced CLK was 1 last cycle and is 0 now. All bus actions key off fall.
//  - Accept: tx_valid && tx_ready at a posedge latches tx_data and parity = ~^tx_data; next cycle state=INHIBIT.
//  - tx_valid while busy is ignored. The held byte is not overwritten.
//  - INHIBIT: clk_oe=1, dat_oe=0 for exactly INHIBIT_CYCLES cycles. Then dat_oe=1 (start bit) for 1 cycle
//    with clk still low, then clk_oe=0 -> REQ.
//  - REQ / SEND, on each fall (bit_cnt counts falls 1..11):
//    falls 1-8: dat_oe <= ~data[fall-1]; fall 9: dat_oe <= ~parity; fall 10: dat_oe <= 0 (stop).
//    The new DAT value is applied on the cycle after fall is detected.
//  - ACK: on fall 11, sample synced DAT. 0 -> ack ok; 1 -> ack_err flag set.
//  - WAIT_IDLE: wait until synced CLK=1 and DAT=1. Then IDLE, done=1 for 1 cycle, ack_err pulses in the same cycle if flagged.
//  - Timeout: the counter clears on entry to REQ and on every fall. It is active in REQ, SEND, ACK and WAIT_IDLE.
//    When it reaches TIMEOUT_CYCLES: both oe=0, timeout_err=1 for 1 cycle, state=IDLE.
//  - States: IDLE -> INHIBIT -> START -> REQ -> SEND -> ACK -> WAIT_IDLE -> IDLE. Any timeout -> IDLE.
//  - Simultaneous fall and timeout in the same cycle: fall wins and the counter clears.
//  - The counter saturates and never wraps. bit_cnt is 4 bits and never exceeds 11.
// TESTING
//  Bench parameters: INHIBIT_CYCLES=20, TIMEOUT_CYCLES=200. The device model clocks with a 40-cycle period and releases both lines after ACK.
//  1. Send 0xED with ACK -> CLK held low exactly 20 cycles; DAT on the wire is 0, then 1,0,1,1,0,1,1,1, parity 1, stop 1;
//     done=1 for 1 cycle, ack_err=0, tx_ready returns to 1.
//  2. Parity: send 0x00 -> parity 1; 0xFF -> parity 1; 0x01 -> parity 0. Check the bit after the 8th data bit.
//  3. Device model holds DAT high at fall 11 -> done=1 and ack_err=1 in the same cycle, state IDLE.
//  4. Device never clocks after the request -> timeout_err pulses 200 cycles after entering REQ; both oe=0; done never asserts.
//  5. Pulse tx_valid with 0x55 during the 0xED frame -> ignored; wire shows 0xED only.
//  6. Assert resetn=0 at fall 5 of a frame -> ps2_clk_oe=ps2_dat_oe=0 with no clock edge; after release, a new 0xFF send completes normally.

Source files
------------

// File: rtl/ps2_host_tx.sv
// ---------------------------------------------------------------------------
// ps2_host_tx
//   Host-to-device PS/2 transmitter. Sends one command byte to the keyboard
//   over the open-drain CLK/DAT pair. The frame is start, 8 data bits LSB
//   first, odd parity, stop, then the device ACK. The *_oe outputs request a
//   low drive on the pin. The top level turns them into tri-state pads.
//
// Ports
//   CLOCK_50     in   system clock
//   resetn       in   asynchronous active-low reset
//   ps2_clk_in   in   PS2_CLK pin level (asynchronous)
//   ps2_dat_in   in   PS2_DAT pin level (asynchronous)
//   ps2_clk_oe   out  1 = pull PS2_CLK low, 0 = release
//   ps2_dat_oe   out  1 = pull PS2_DAT low, 0 = release
//   tx_data      in   command byte
//   tx_valid     in   send request, taken only while tx_ready = 1
//   tx_ready     out  high only in IDLE
//   busy         out  high in every state except IDLE
//   done         out  1-cycle pulse when a transfer finishes (ACK or not)
//   ack_err      out  1-cycle pulse with done when the device did not ACK
//   timeout_err  out  1-cycle pulse when a transfer is aborted by timeout
// ---------------------------------------------------------------------------
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000,
    parameter int CNT_W          = 20
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic       timeout_err
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_INHIBIT   = 3'd1;
    localparam logic [2:0] S_START     = 3'd2;
    localparam logic [2:0] S_REQ       = 3'd3;
    localparam logic [2:0] S_SEND      = 3'd4;
    localparam logic [2:0] S_ACK       = 3'd5;
    localparam logic [2:0] S_WAIT_IDLE = 3'd6;

    localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX      = '1;

    // Two-stage synchronisers, plus one extra CLK stage for edge detection.
    logic clk_meta_q, clk_sync_q, clk_last_q;
    logic dat_meta_q, dat_sync_q;
    logic fall;

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       data_q, data_d;
    logic             parity_q, parity_d;
    logic             clk_oe_q, clk_oe_d;
    logic             dat_oe_q, dat_oe_d;
    logic             ack_flag_q, ack_flag_d;
    logic             done_q, done_d;
    logic             ack_err_q, ack_err_d;
    logic             timeout_err_q, timeout_err_d;

    // The idle bus level is high, so the synchronisers reset to 1. This keeps
    // a phantom falling edge from appearing right after reset.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            clk_meta_q <= 1'b1;
            clk_sync_q <= 1'b1;
            clk_last_q <= 1'b1;
            dat_meta_q <= 1'b1;
            dat_sync_q <= 1'b1;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples the pre-edge values, which keeps the chain ordered.
            clk_meta_q <= ps2_clk_in;
            clk_sync_q <= clk_meta_q;
            clk_last_q <= clk_sync_q;
            dat_meta_q <= ps2_dat_in;
            dat_sync_q <= dat_meta_q;
        end
    end

    assign fall = clk_last_q & ~clk_sync_q;

    always_comb begin
        // NOTE: every signal driven here gets a default first. A path that
        // leaves a signal unassigned would otherwise infer a latch.
        state_d       = state_q;
        cnt_d         = cnt_q;
        bit_cnt_d     = bit_cnt_q;
        data_d        = data_q;
        parity_d      = parity_q;
        clk_oe_d      = clk_oe_q;
        dat_oe_d      = dat_oe_q;
        ack_flag_d    = ack_flag_q;
        done_d        = 1'b0;
        ack_err_d     = 1'b0;
        timeout_err_d = 1'b0;
        cnt_inc       = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

        case (state_q)
            S_IDLE: begin
                clk_oe_d = 1'b0;
                dat_oe_d = 1'b0;
                if (tx_valid) begin
                    data_d     = tx_data;
                    parity_d   = ~^tx_data;
                    cnt_d      = '0;
                    bit_cnt_d  = 4'd0;
                    ack_flag_d = 1'b0;
                    clk_oe_d   = 1'b1;
                    state_d    = S_INHIBIT;
                end
            end

            S_INHIBIT: begin
                if (cnt_q == INHIBIT_LAST) begin
                    dat_oe_d = 1'b1;              // start bit, CLK still low
                    state_d  = S_START;
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            S_START: begin
                clk_oe_d = 1'b0;                  // release CLK: request-to-send
                cnt_d    = '0;
                state_d  = S_REQ;
            end

            S_REQ, S_SEND, S_ACK, S_WAIT_IDLE: begin
                if (state_q == S_WAIT_IDLE && clk_sync_q && dat_sync_q) begin
                    done_d    = 1'b1;
                    ack_err_d = ack_flag_q;
                    state_d   = S_IDLE;
                end else if (fall) begin
                    // A fall always beats a timeout in the same cycle.
                    cnt_d = '0;
                    if (state_q == S_REQ || state_q == S_SEND) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q < 4'd8)
                            dat_oe_d = ~data_q[bit_cnt_q[2:0]];
                        else if (bit_cnt_q == 4'd8)
                            dat_oe_d = ~parity_q;
                        else
                            dat_oe_d = 1'b0;      // stop bit: release DAT
                        state_d = (bit_cnt_q == 4'd9) ? S_ACK : S_SEND;
                    end else if (state_q == S_ACK) begin
                        bit_cnt_d  = bit_cnt_q + 4'd1;
                        ack_flag_d = dat_sync_q;  // high DAT means no ACK
                        state_d    = S_WAIT_IDLE;
                    end
                end else if (cnt_q >= TIMEOUT_LAST) begin
                    dat_oe_d      = 1'b0;
                    clk_oe_d      = 1'b0;
                    timeout_err_d = 1'b1;
                    state_d       = S_IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            default: begin
                clk_oe_d = 1'b0;
                dat_oe_d = 1'b0;
                state_d  = S_IDLE;
            end
        endcase
    end

    // Reset clears both output enables at once, so the lines are released
    // without waiting for a clock edge.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            bit_cnt_q     <= 4'd0;
            data_q        <= 8'h00;
            parity_q      <= 1'b0;
            clk_oe_q      <= 1'b0;
            dat_oe_q      <= 1'b0;
            ack_flag_q    <= 1'b0;
            done_q        <= 1'b0;
            ack_err_q     <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            data_q        <= data_d;
            parity_q      <= parity_d;
            clk_oe_q      <= clk_oe_d;
            dat_oe_q      <= dat_oe_d;
            ack_flag_q    <= ack_flag_d;
            done_q        <= done_d;
            ack_err_q     <= ack_err_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_dat_oe  = dat_oe_q;
    assign tx_ready    = (state_q == S_IDLE);
    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;
    assign ack_err     = ack_err_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// ---------------------------------------------------------------------------
// tb_ps2_host_tx
//   Self-checking bench for ps2_host_tx. A PS/2 device model clocks the bus
//   with a 40-cycle period. It reads each bit on the rising CLK edge and pulls
//   DAT low for the ACK when asked to. Expected frames come from the byte
//   itself: start 0, data LSB first, odd parity, stop 1.
// ---------------------------------------------------------------------------
module tb_ps2_host_tx;

    localparam int INH  = 20;
    localparam int TMO  = 200;
    localparam int HALF = 20;

    logic       CLOCK_50 = 1'b0;
    logic       resetn;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       ps2_clk_oe, ps2_dat_oe, tx_ready, busy, done, ack_err, timeout_err;
    logic       dev_clk_low = 1'b0;
    logic       dev_dat_low = 1'b0;
    logic       ps2_clk_w, ps2_dat_w;

    // Open-drain wire: low if either side pulls it low.
    assign ps2_clk_w = !(ps2_clk_oe || dev_clk_low);
    assign ps2_dat_w = !(ps2_dat_oe || dev_dat_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .TIMEOUT_CYCLES (TMO),
        .CNT_W          (20)
    ) dut (
        .CLOCK_50    (CLOCK_50),
        .resetn      (resetn),
        .ps2_clk_in  (ps2_clk_w),
        .ps2_dat_in  (ps2_dat_w),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_dat_oe  (ps2_dat_oe),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .busy        (busy),
        .done        (done),
        .ack_err     (ack_err),
        .timeout_err (timeout_err)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    int tests = 0;
    int fails = 0;

    // Cumulative event counters, sampled away from the active edge.
    int mon_inh = 0, mon_start = 0, mon_done = 0, mon_done_rdy = 0;
    int mon_ackerr = 0, mon_ackerr_done = 0, mon_to = 0;

    always @(negedge CLOCK_50) begin
        if (ps2_clk_oe && !ps2_dat_oe) mon_inh++;
        if (ps2_clk_oe && ps2_dat_oe)  mon_start++;
        if (done)                      mon_done++;
        if (done && tx_ready)          mon_done_rdy++;
        if (ack_err)                   mon_ackerr++;
        if (ack_err && done)           mon_ackerr_done++;
        if (timeout_err)               mon_to++;
    end

    int dev_falls = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference frame: bit 0 start, bits 1..8 data, bit 9 parity, bit 10 stop.
    function automatic logic [10:0] frame_bits(input logic [7:0] b);
        logic [10:0] f;
        f[0]   = 1'b0;
        f[8:1] = b;
        f[9]   = ($countones(b) % 2 == 0);
        f[10]  = 1'b1;
        return f;
    endfunction

    task automatic send(input logic [7:0] b);
        @(negedge CLOCK_50);
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge CLOCK_50);
        tx_valid = 1'b0;
    endtask

    task automatic dev_frame(input bit ack, output logic [10:0] got, output bit ok);
        bit seen;
        seen = 1'b0;
        ok   = 1'b0;
        got  = '0;
        dev_falls = 0;
        for (int n = 0; n < 1000 && !seen; n++) begin
            @(negedge CLOCK_50);
            if (ps2_clk_w && !ps2_dat_w) seen = 1'b1;
        end
        if (seen) begin
            repeat (5) @(negedge CLOCK_50);
            got[0] = ps2_dat_w;
            for (int i = 1; i <= 11; i++) begin
                dev_clk_low = 1'b1;
                dev_falls   = i;
                repeat (HALF) @(negedge CLOCK_50);
                dev_clk_low = 1'b0;
                if (i <= 10) got[i] = ps2_dat_w;
                if (i == 10) dev_dat_low = ack;
                if (i == 11) dev_dat_low = 1'b0;
                repeat (HALF) @(negedge CLOCK_50);
            end
            ok = 1'b1;
        end
    endtask

    task automatic run_frame(input string tag, input logic [7:0] b, input bit ack, input bit inject);
        logic [10:0] got, exp_f;
        bit ok, done_seen;
        int s_inh, s_start, s_done, s_rdy, s_ae, s_aed, s_to;
        s_inh = mon_inh; s_start = mon_start; s_done = mon_done; s_rdy = mon_done_rdy;
        s_ae = mon_ackerr; s_aed = mon_ackerr_done; s_to = mon_to;
        exp_f = frame_bits(b);
        fork
            send(b);
            dev_frame(ack, got, ok);
            if (inject) begin
                for (int n = 0; n < 2000 && dev_falls < 3; n++) @(negedge CLOCK_50);
                tx_data  = 8'h55;
                tx_valid = 1'b1;
                @(negedge CLOCK_50);
                tx_valid = 1'b0;
            end
        join
        done_seen = 1'b0;
        for (int n = 0; n < 100 && !done_seen; n++) begin
            @(negedge CLOCK_50);
            if (mon_done != s_done) done_seen = 1'b1;
        end
        repeat (5) @(negedge CLOCK_50);
        check({tag, "_request_seen"}, 32'(ok), 32'd1);
        check({tag, "_wire_bits"},    32'(got), 32'(exp_f));
        check({tag, "_parity"},       32'(got[9]), 32'(exp_f[9]));
        check({tag, "_done_seen"},    32'(done_seen), 32'd1);
        check({tag, "_inhibit_len"},  32'(mon_inh - s_inh), 32'(INH));
        check({tag, "_start_len"},    32'(mon_start - s_start), 32'd1);
        check({tag, "_done_cycles"},  32'(mon_done - s_done), 32'd1);
        check({tag, "_done_idle"},    32'(mon_done_rdy - s_rdy), 32'd1);
        check({tag, "_ackerr_cyc"},   32'(mon_ackerr - s_ae), 32'(!ack));
        check({tag, "_ackerr_done"},  32'(mon_ackerr_done - s_aed), 32'(!ack));
        check({tag, "_no_timeout"},   32'(mon_to - s_to), 32'd0);
        check({tag, "_idle_outs"},    32'({tx_ready, busy, ps2_clk_oe, ps2_dat_oe}), 32'b1000);
    endtask

    initial begin
        int n, s_done, s_to, s_inh;
        bit found;
        logic [10:0] junk;
        bit junk_ok;

        resetn   = 1'b0;
        tx_data  = 8'h00;
        tx_valid = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        check("reset_outs", 32'({ps2_clk_oe, ps2_dat_oe, tx_ready, busy, done, ack_err, timeout_err}),
              32'b0010000);
        resetn = 1'b1;
        repeat (3) @(negedge CLOCK_50);

        // Basic frame, parity corners, missing ACK, and busy-time request.
        run_frame("ed_ack",   8'hED, 1'b1, 1'b0);
        run_frame("p00",      8'h00, 1'b1, 1'b0);
        run_frame("pff",      8'hFF, 1'b1, 1'b0);
        run_frame("p01",      8'h01, 1'b1, 1'b0);
        run_frame("no_ack",   8'hA6, 1'b0, 1'b0);
        run_frame("ignore55", 8'hED, 1'b1, 1'b1);
        repeat (50) @(negedge CLOCK_50);
        check("ignore55_no_refire", 32'({ps2_clk_oe, busy}), 32'd0);

        for (int r = 0; r < 3; r++) begin
            logic [7:0] rb;
            rb = 8'($urandom);
            run_frame($sformatf("rand%0d", r), rb, 1'($urandom_range(0, 1)), 1'b0);
        end

        // Device never clocks: abort after TMO cycles in REQ.
        s_done = mon_done;
        s_to   = mon_to;
        send(8'hA5);
        found = 1'b0;
        for (int k = 0; k < 200 && !found; k++) begin
            @(negedge CLOCK_50);
            if (!ps2_clk_oe && ps2_dat_oe) found = 1'b1;
        end
        check("to_request_seen", 32'(found), 32'd1);
        n = 0;
        found = 1'b0;
        for (int k = 0; k < 1000 && !found; k++) begin
            @(negedge CLOCK_50);
            n++;
            if (timeout_err) found = 1'b1;
        end
        check("to_pulse_seen", 32'(found), 32'd1);
        check("to_latency",    32'(n), 32'(TMO));
        check("to_outs",       32'({ps2_clk_oe, ps2_dat_oe, tx_ready, done}), 32'b0010);
        repeat (5) @(negedge CLOCK_50);
        check("to_pulse_width", 32'(mon_to - s_to), 32'd1);
        check("to_no_done",     32'(mon_done - s_done), 32'd0);

        // Reset during fall 5 releases both lines with no clock edge.
        s_done = mon_done;
        s_to   = mon_to;
        fork
            dev_frame(1'b1, junk, junk_ok);
            send(8'h3C);
            begin
                for (int k = 0; k < 2000 && dev_falls < 5; k++) @(negedge CLOCK_50);
                check("rst_reached_fall5", 32'(dev_falls), 32'd5);
                #3 resetn = 1'b0;
                #1 check("rst_async_release", 32'({ps2_clk_oe, ps2_dat_oe, tx_ready, busy}), 32'b0010);
                @(negedge CLOCK_50);
                @(negedge CLOCK_50);
                resetn = 1'b1;
            end
        join
        s_inh = mon_inh;
        repeat (TMO + 50) @(negedge CLOCK_50);
        check("rst_no_resume", 32'(mon_inh - s_inh), 32'd0);
        check("rst_no_done",   32'(mon_done - s_done), 32'd0);
        check("rst_no_to",     32'(mon_to - s_to), 32'd0);
        run_frame("after_rst_ff", 8'hFF, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
